// File: rtl/io_pattern_engine_pkg.sv
// Shared types for the pad pattern engine: mode and FSM encodings,
// plus maximal-length LFSR tap masks for data widths 4..16.
package io_pattern_engine_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_LOOP  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Fibonacci masks for a left-shifting LFSR fed by the parity of (state & mask)
    function automatic logic [15:0] default_taps(input int d);
        logic [15:0] t;
        t = 16'h0000;
        case (d)
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0E08;
            13:      t = 16'h1C80;
            14:      t = 16'h3802;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = 16'h0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/io_pattern_engine_if.sv
// Pad bundle of the pattern engine: io_in from pads, io_out / io_oeb to pads.
// master = the engine, slave = the pad ring (or a bench standing in for it).
interface io_pattern_engine_if #(
    parameter int NUM_IO = 10
);
    logic [NUM_IO-1:0] io_in;
    logic [NUM_IO-1:0] io_out;
    logic [NUM_IO-1:0] io_oeb;

    modport master (input io_in, output io_out, output io_oeb);
    modport slave (output io_in, input io_out, input io_oeb);
endinterface

// File: rtl/io_pattern_engine_sync.sv
// io_sync: W-bit two-flop synchroniser, async active-low reset to 0.
// Ports: clk, rst_n, d (asynchronous input), q (synchronised output).
module io_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/io_pattern_engine.sv
// Bring-up / pad-test engine: pads 1:0 select a mode, data pads show a
// counter, walking one, LFSR, or a loopback self-check with sticky error pad.
// Ports: clk, rst_n (async, active low), pads (io_in / io_out / io_oeb).
module io_pattern_engine
    import io_pattern_engine_pkg::*;
#(
    parameter int                NUM_IO       = 10,
    parameter int                PRESCALE_MAX = 1000000,
    parameter logic [NUM_IO-3:0] LFSR_TAPS    = 'hB8,
    parameter logic [NUM_IO-3:0] LFSR_SEED    = 'h01
) (
    input logic                  clk,
    input logic                  rst_n,
    io_pattern_engine_if.master  pads
);
    localparam int D  = NUM_IO - 2;
    localparam int L  = (D - 1) / 2;
    localparam int CW = $clog2(PRESCALE_MAX);
    localparam logic [CW-1:0] TOP = CW'(PRESCALE_MAX - 1);
    localparam logic [CW-1:0] MID = CW'(PRESCALE_MAX / 2);
    localparam logic [D-1:0]  SEED = (LFSR_SEED == '0) ? D'(1) : LFSR_SEED;

    logic [CW-1:0]     pre;
    logic              tick;
    logic              cmp;
    state_e            state, state_n;
    mode_e             mode_q, mode_n;
    logic [1:0]        mode_s;
    logic [L-1:0]      loop_s;
    logic              err, err_n;
    logic [D-1:0]      cnt, walk, lfsr;
    logic [D-1:0]      cnt_b, walk_b, lfsr_b;
    logic [NUM_IO-1:0] out_q, out_n;
    logic [NUM_IO-1:0] oeb_q, oeb_n;

    io_sync #(.W(2)) u_mode_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pads.io_in[1:0]),
        .q     (mode_s)
    );

    io_sync #(.W(L)) u_loop_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pads.io_in[2*L+2:L+3]),
        .q     (loop_s)
    );

    assign tick = (pre == TOP);
    // Compare sits mid-period so the looped value has settled through the sync
    assign cmp  = (pre == MID) && (state == ST_RUN) && (mode_q == MODE_LOOP);

    assign pads.io_out = out_q;
    assign pads.io_oeb = oeb_q;

    // *_b is the pattern base shown on this tick (re-initialised on a mode change)
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        err_n   = err;
        cnt_b   = cnt;
        walk_b  = walk;
        lfsr_b  = lfsr;
        out_n   = out_q;
        oeb_n   = oeb_q;
        if (cmp && (loop_s != out_q[L+2:3])) begin
            err_n = 1'b1;
        end
        if (tick) begin
            state_n = ST_RUN;
            mode_n  = mode_e'(mode_s);
            if (mode_n != mode_q) begin
                cnt_b  = '0;
                walk_b = D'(1);
                lfsr_b = SEED;
                err_n  = 1'b0;
            end
            out_n      = '0;
            oeb_n      = '0;
            oeb_n[1:0] = 2'b11;
            unique case (mode_n)
                MODE_COUNT: out_n[NUM_IO-1:2] = cnt_b;
                MODE_WALK:  out_n[NUM_IO-1:2] = walk_b;
                MODE_LFSR:  out_n[NUM_IO-1:2] = lfsr_b;
                MODE_LOOP: begin
                    out_n[2]           = err_n;
                    out_n[L+2:3]       = cnt_b[L-1:0];
                    oeb_n[2*L+2:L+3]   = '1;
                end
            endcase
        end else if (state == ST_RUN && mode_q == MODE_LOOP) begin
            out_n[2] = err_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_COUNT;
            pre    <= '0;
            err    <= 1'b0;
            cnt    <= '0;
            walk   <= D'(1);
            lfsr   <= SEED;
            out_q  <= '0;
            oeb_q  <= '1;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            err    <= err_n;
            out_q  <= out_n;
            oeb_q  <= oeb_n;
            pre    <= tick ? '0 : pre + CW'(1);
            if (tick) begin
                cnt  <= cnt_b + D'(1);
                walk <= {walk_b[D-2:0], walk_b[D-1]};
                lfsr <= {lfsr_b[D-2:0], ^(lfsr_b & LFSR_TAPS)};
            end
        end
    end
endmodule
